// File: rtl/constants_pkg.sv
// Shared widths, depths and the feeder FSM encoding for the matrix-vector datapath.
package constants_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 20;
  localparam int W_DEPTH    = 16;
  localparam int X_DEPTH    = 4;
  localparam int MAT_DIM    = 4;
  localparam int CFG_ADDR_W = 5;
  localparam int X_BASE     = 16;

  typedef enum logic [1:0] {
    F_IDLE,
    F_SEND_W,
    F_SEND_X,
    F_COLLECT
  } feeder_state_t;
endpackage

// File: rtl/matrix_feeder_stream_tx_reg.sv
// One-entry valid/ready output register; the word appears one cycle after load.
// Under backpressure vld and data are held until the consumer accepts; a load overrides a drain.
module stream_tx_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             rdy,
  output logic             vld,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      data <= load_data;
    end else if (rdy) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/matrix_feeder.sv
// Streams W then X to the matrix core and collects MAT_DIM results; res_data has 1-cycle latency.
// Source side holds words under backpressure; collect side always ready, guarded by an idle watchdog.
module matrix_feeder
  import constants_pkg::*;
#(
  parameter int DATA_WIDTH     = constants_pkg::DATA_WIDTH,
  parameter int ACC_WIDTH      = constants_pkg::ACC_WIDTH,
  parameter int W_DEPTH        = constants_pkg::W_DEPTH,
  parameter int X_DEPTH        = constants_pkg::X_DEPTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [CFG_ADDR_W-1:0]      cfg_addr,
  input  logic [DATA_WIDTH-1:0]      cfg_wdata,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  input  logic [$clog2(X_DEPTH)-1:0] res_addr,
  output logic [ACC_WIDTH-1:0]       res_data,
  output logic                       src_vld,
  output logic [DATA_WIDTH-1:0]      src_data,
  input  logic                       src_rdy,
  input  logic                       snk_vld,
  input  logic [ACC_WIDTH-1:0]       snk_data,
  output logic                       snk_rdy
);

  localparam int NWORDS = W_DEPTH + X_DEPTH;
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RCNT_W = $clog2(X_DEPTH);
  localparam logic [CFG_ADDR_W-1:0] LAST_W_IDX = CFG_ADDR_W'(W_DEPTH - 1);
  localparam logic [CFG_ADDR_W-1:0] LAST_IDX   = CFG_ADDR_W'(NWORDS - 1);
  localparam logic [CFG_ADDR_W-1:0] N_WORDS    = CFG_ADDR_W'(NWORDS);
  localparam logic [RCNT_W-1:0]     LAST_RES   = RCNT_W'(X_DEPTH - 1);
  localparam logic [WDOG_W-1:0]     WDOG_LAST  = WDOG_W'(TIMEOUT_CYCLES - 1);

  // W occupies words 0..W_DEPTH-1 and X follows directly, matching the cfg address map.
  logic [DATA_WIDTH-1:0] mem    [NWORDS];
  logic [ACC_WIDTH-1:0]  result [X_DEPTH];

  feeder_state_t         state, state_n;
  logic [CFG_ADDR_W-1:0] sidx, sidx_n, nidx;
  logic [RCNT_W-1:0]     rcnt, rcnt_n;
  logic [WDOG_W-1:0]     wdog, wdog_n;
  logic                  done_n, err_n;
  logic                  push, res_we, cfg_hit;
  logic [DATA_WIDTH-1:0] push_data;

  assign cfg_hit = cfg_we && (cfg_addr < N_WORDS) && (state == F_IDLE);
  assign nidx    = (sidx == LAST_IDX) ? '0 : sidx + 1'b1;
  assign busy    = (state != F_IDLE);
  assign snk_rdy = (state == F_COLLECT);

  always_comb begin
    state_n   = state;
    sidx_n    = sidx;
    rcnt_n    = rcnt;
    wdog_n    = wdog;
    done_n    = 1'b0;
    err_n     = err;
    push      = 1'b0;
    push_data = mem[nidx];
    res_we    = 1'b0;
    case (state)
      F_IDLE: begin
        if (start) begin
          state_n   = F_SEND_W;
          push      = 1'b1;
          // A write landing on the same edge as start must be the word that goes out.
          push_data = (cfg_hit && cfg_addr == '0) ? cfg_wdata : mem[0];
          sidx_n    = '0;
          rcnt_n    = '0;
          wdog_n    = '0;
          err_n     = 1'b0;
        end
      end
      F_SEND_W, F_SEND_X: begin
        if (src_vld && src_rdy) begin
          if (sidx == LAST_IDX) begin
            state_n = F_COLLECT;
          end else begin
            push   = 1'b1;
            sidx_n = nidx;
            if (sidx == LAST_W_IDX) state_n = F_SEND_X;
          end
        end
      end
      F_COLLECT: begin
        if (snk_vld) begin
          res_we = 1'b1;
          wdog_n = '0;
          rcnt_n = rcnt + 1'b1;
          if (rcnt == LAST_RES) begin
            state_n = F_IDLE;
            done_n  = 1'b1;
          end
        end else if (wdog == WDOG_LAST) begin
          state_n = F_IDLE;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else begin
          wdog_n = wdog + 1'b1;
        end
      end
      default: state_n = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= F_IDLE;
      sidx     <= '0;
      rcnt     <= '0;
      wdog     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      res_data <= '0;
    end else begin
      state    <= state_n;
      sidx     <= sidx_n;
      rcnt     <= rcnt_n;
      wdog     <= wdog_n;
      done     <= done_n;
      err      <= err_n;
      res_data <= result[res_addr];
    end
  end

  // Storage is deliberately left out of reset so contents survive an aborted job.
  always_ff @(posedge clk) begin
    if (rst_n && cfg_hit) mem[cfg_addr] <= cfg_wdata;
    if (rst_n && res_we)  result[rcnt]  <= snk_data;
  end

  stream_tx_reg #(.WIDTH(DATA_WIDTH)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (push),
    .load_data (push_data),
    .rdy       (src_rdy),
    .vld       (src_vld),
    .data      (src_data)
  );

endmodule
